debounced_input_bank: RTL and testbench
=======================================

DEBOUNCED_INPUT_BANK -- requirements
Module: debounced_input_bank

Interface
REQ-001 Parameter N_CH, default 4: number of independent input channels, 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles needed to accept a new level, >=1.
REQ-003 Parameter EDGE_MODE, default 0: pulse source; 0 = rising, 1 = falling, 2 = any edge of the debounced level.
REQ-004 Parameter REPEAT_DELAY, default 0: auto-repeat start, in cycles of debounced-high hold; 0 disables auto-repeat and held_out.
REQ-005 Parameter REPEAT_PERIOD, default 1: cycles between auto-repeat pulses after REPEAT_DELAY, >=1.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst  input  1  reset; synchronous and active-high.
REQ-008 raw_in  input  N_CH  asynchronous button or switch levels, one bit per channel.
REQ-009 level_out  output  N_CH  debounced, registered level per channel.
REQ-010 pulse_out  output  N_CH  one-cycle event pulse per channel (edge or auto-repeat).
REQ-011 held_out  output  N_CH  high while the channel has been debounced-high for at least REPEAT_DELAY cycles.

Function
REQ-012 Channels shall be fully independent; behaviour of channel i shall not depend on any other channel.
REQ-013 Each raw_in bit shall pass through a 2-flop synchronizer before any other logic.
REQ-014 The debounce counter shall increment each cycle the synchronized bit differs from level_out, and clear to 0 in any cycle they match.
REQ-015 When the counter equals DEBOUNCE_CYCLES-1 and the mismatch persists, level_out shall take the synchronized value at that edge and the counter shall clear.
REQ-016 Latency: a clean raw_in change sampled first at edge t0 appears on level_out after edge t0+DEBOUNCE_CYCLES+1 (DEBOUNCE_CYCLES+2 edges in total).
REQ-017 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles shall never change level_out or produce a pulse.
REQ-018 An edge pulse shall assert in the same cycle level_out first shows the new value, for exactly one cycle, filtered by EDGE_MODE.
REQ-019 Per-channel hold FSM, states IDLE and HOLD, plus REPEAT when REPEAT_DELAY>0:
 - IDLE -> HOLD when level_out rises; hold counter = 0.
 - HOLD: counter increments each cycle; counter == REPEAT_DELAY-1 -> REPEAT, pulse_out = 1, held_out = 1 from that cycle.
 - REPEAT: period counter wraps every REPEAT_PERIOD cycles, pulse_out = 1 on each wrap.
 - Any state -> IDLE in the cycle level_out falls; held_out = 0 in that same cycle.
REQ-020 With REPEAT_DELAY=0 the FSM shall stay in IDLE; held_out is constant 0.
REQ-021 Auto-repeat pulses shall be ORed into pulse_out regardless of EDGE_MODE; coincident edge and repeat events yield a single 1-cycle pulse.
REQ-022 Counter widths shall be $clog2 of the terminal value (minimum 1 bit); counters shall never overflow or wrap except as specified in REQ-019.

Reset
REQ-023 While rst is high at a clock edge: synchronizers, level_out, pulse_out and held_out shall be 0; all counters shall be 0; FSM shall be IDLE.
REQ-024 If raw_in is held high through reset release, the full REQ-016 latency shall apply before level_out rises, and it shall rise with a rising-edge pulse.
REQ-025 Reset asserted mid-debounce or mid-repeat shall discard all progress, with no residual pulse after rst deasserts.

Structure
REQ-026 Shared package input_pkg shall hold the EDGE_MODE encodings (EDGE_RISE, EDGE_FALL, EDGE_ANY).
REQ-027 One sub-module, debounce_channel (synchronizer, debounce counter, edge logic, hold FSM), shall be instantiated N_CH times via generate.
REQ-028 Illegal parameter values shall stop elaboration with an error.

Verification
REQ-029 N_CH=4, DEBOUNCE_CYCLES=4: raw_in[0] rises and stays high -> level_out[0] and pulse_out[0] rise after exactly 6 edges; pulse_out[0] is 1 cycle.
REQ-030 DEBOUNCE_CYCLES=4: raw_in[1] high for 3 cycles then low -> level_out[1] and pulse_out[1] stay 0.
REQ-031 EDGE_MODE=1: press then release on ch2 -> no pulse on press; one pulse in the cycle level_out[2] falls.
REQ-032 REPEAT_DELAY=8, REPEAT_PERIOD=3, hold ch3 for 20 cycles after debounce -> pulses at hold cycles 0, 7, 10, 13, 16, 19; held_out[3] high from cycle 7; cleared on release.
REQ-033 rst pulsed mid-debounce (counter=2) and mid-repeat -> all outputs 0 next cycle; a fresh full latency applies after release.
REQ-034 All four channels toggled simultaneously with different glitch widths -> each channel matches an independent single-channel model.

Source files
------------

// File: rtl/input_pkg.sv
// input_pkg: edge-mode encodings, hold FSM states and counter sizing shared by the input bank
package input_pkg;
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} hold_state_t;

    // Bits needed to hold a counter whose largest value is terminal.
    function automatic int cnt_width(input int terminal);
        return terminal > 1 ? $clog2(terminal + 1) : 1;
    endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one input's synchronizer, debounce filter, edge detect and hold/auto-repeat FSM
module debounce_channel
    import input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_MODE       = EDGE_RISE,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse,
    output logic held
);
    localparam int DW = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam int HW = cnt_width(REPEAT_DELAY > 0 ? REPEAT_DELAY - 1 : 0);
    localparam int PW = cnt_width(REPEAT_PERIOD - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_DELAY > 1 ? REPEAT_DELAY - 2 : 0);
    localparam logic [PW-1:0] PER_LAST  = PW'(REPEAT_PERIOD - 1);

    logic          sync_a, sync_b;
    logic [DW-1:0] deb_cnt;
    logic [HW-1:0] hold_cnt;
    logic [PW-1:0] per_cnt;
    hold_state_t   state;
    logic          accept, rise, fall, edge_hit;

    assign accept   = sync_b != level && deb_cnt == DEB_LAST;
    assign rise     = accept && sync_b;
    assign fall     = accept && !sync_b;
    assign edge_hit = EDGE_MODE == EDGE_RISE ? rise : EDGE_MODE == EDGE_FALL ? fall : rise || fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            level   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync_a  <= raw;
            sync_b  <= sync_a;
            level   <= accept ? sync_b : level;
            deb_cnt <= (sync_b == level || accept) ? '0 : deb_cnt + 1'b1;
        end
    end

    // hold_cnt tracks the hold cycle index, so the transition fires when the next cycle is REPEAT_DELAY-1
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            per_cnt  <= '0;
            pulse    <= 1'b0;
            held     <= 1'b0;
        end else if (REPEAT_DELAY == 0 || fall) begin
            state    <= IDLE;
            hold_cnt <= '0;
            per_cnt  <= '0;
            pulse    <= edge_hit;
            held     <= 1'b0;
        end else begin
            pulse <= edge_hit;
            case (state)
                IDLE: if (rise) begin
                    state    <= REPEAT_DELAY == 1 ? REPEAT : HOLD;
                    held     <= REPEAT_DELAY == 1;
                    pulse    <= edge_hit || REPEAT_DELAY == 1;
                    hold_cnt <= '0;
                    per_cnt  <= '0;
                end
                HOLD: if (hold_cnt == HOLD_LAST) begin
                    state   <= REPEAT;
                    held    <= 1'b1;
                    pulse   <= 1'b1;
                    per_cnt <= '0;
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
                REPEAT: begin
                    pulse   <= edge_hit || per_cnt == PER_LAST;
                    per_cnt <= per_cnt == PER_LAST ? '0 : per_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/debounced_input_bank.sv
// debounced_input_bank: N_CH independent debounced inputs with edge and auto-repeat pulses
module debounced_input_bank
    import input_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_MODE       = EDGE_RISE,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] pulse_out,
    output logic [N_CH-1:0] held_out
);
    if (N_CH < 1 || N_CH > 32) begin : g_bad_n_ch
        $error("N_CH must be in 1..32");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 1");
    end
    if (EDGE_MODE != EDGE_RISE && EDGE_MODE != EDGE_FALL && EDGE_MODE != EDGE_ANY) begin : g_bad_edge
        $error("EDGE_MODE must be 0, 1 or 2");
    end
    if (REPEAT_DELAY < 0) begin : g_bad_delay
        $error("REPEAT_DELAY must be >= 0");
    end
    if (REPEAT_PERIOD < 1) begin : g_bad_period
        $error("REPEAT_PERIOD must be >= 1");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .EDGE_MODE      (EDGE_MODE),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw_in[i]),
            .level(level_out[i]),
            .pulse(pulse_out[i]),
            .held (held_out[i])
        );
    end
endmodule

// File: tb/tb_debounced_input_bank.sv
// tb_debounced_input_bank: scoreboard bench; one rising-edge/auto-repeat bank and one falling-edge bank share raw_in
module tb_debounced_input_bank;
    localparam int DEB = 4;
    localparam int RD  = 8;
    localparam int RP  = 3;

    typedef struct {
        int         cyc;
        logic [3:0] lvl;
        logic [3:0] pa;
        logic [3:0] ha;
        logic [3:0] pb;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] raw_in = 4'b0001;
    logic [3:0] level_a, pulse_a, held_a, level_b, pulse_b, held_b;
    int         cyc = 0;
    int         passed = 0;
    int         total = 0;
    int         st[4];
    int         en[4];
    exp_t       sb[$];
    exp_t       mon_e;

    debounced_input_bank #(.N_CH(4), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_a (
        .clk(clk), .rst(rst), .raw_in(raw_in), .level_out(level_a), .pulse_out(pulse_a), .held_out(held_a)
    );
    debounced_input_bank #(.N_CH(4), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(1), .REPEAT_DELAY(0), .REPEAT_PERIOD(1)) dut_b (
        .clk(clk), .rst(rst), .raw_in(raw_in), .level_out(level_b), .pulse_out(pulse_b), .held_out(held_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected {level, pulse_a, held_a, pulse_b} at step k for one press with raw high over steps [a, b).
    // Level appears DEB+1 steps after a raw change; repeats at hold cycles RD-1, RD-1+RP, ...
    function automatic logic [3:0] exp_ch(input int k, input int a, input int b);
        int   hc;
        logic l, pa, ha, pb;
        if (b - a < DEB) return 4'b0000;
        hc = k - (a + DEB + 1);
        l  = k >= a + DEB + 1 && k < b + DEB + 1;
        pa = l && (hc == 0 || (hc >= RD - 1 && (hc - (RD - 1)) % RP == 0));
        ha = l && hc >= RD - 1;
        pb = k == b + DEB + 1;
        return {l, pa, ha, pb};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, want);
    endtask

    task automatic push(input logic [3:0] lvl, input logic [3:0] pa, input logic [3:0] ha, input logic [3:0] pb);
        exp_t e;
        e.cyc = cyc + 1;
        e.lvl = lvl;
        e.pa  = pa;
        e.ha  = ha;
        e.pb  = pb;
        sb.push_back(e);
    endtask

    task automatic do_reset(input int n, input logic [3:0] r);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            rst    = 1'b1;
            raw_in = r;
            push(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end
    endtask

    task automatic run(input int len);
        logic [3:0] r, l, pa, ha, pb, x;
        for (int k = 0; k < len; k++) begin
            for (int c = 0; c < 4; c++) begin
                r[c]  = k >= st[c] && k < en[c];
                x     = exp_ch(k, st[c], en[c]);
                l[c]  = x[3];
                pa[c] = x[2];
                ha[c] = x[1];
                pb[c] = x[0];
            end
            @(posedge clk);
            #1;
            rst    = 1'b0;
            raw_in = r;
            push(l, pa, ha, pb);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            check("level_a", level_a, mon_e.lvl);
            check("pulse_a", pulse_a, mon_e.pa);
            check("held_a", held_a, mon_e.ha);
            check("level_b", level_b, mon_e.lvl);
            check("pulse_b", pulse_b, mon_e.pb);
            check("held_b", held_b, 4'b0000);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d checks pending", sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        // ch0 held high through reset release, then a long hold into auto-repeat and release
        do_reset(2, 4'b0001);
        st = '{0, 0, 0, 0};
        en = '{13, 0, 0, 0};
        run(22);
        // ch1 glitch one cycle shorter than the debounce window
        en = '{0, 3, 0, 0};
        run(10);
        // ch2 press and release: the falling-edge bank pulses only on release
        en = '{0, 0, 6, 0};
        run(14);
        // ch3 held 22 cycles: repeats at hold cycles 0, 7, 10, 13, 16, 19
        en = '{0, 0, 0, 22};
        run(30);
        // reset mid-debounce (counter at 2), then mid-repeat, each followed by a fresh latency
        en = '{1000, 0, 0, 0};
        run(4);
        do_reset(1, 4'b0001);
        run(14);
        do_reset(1, 4'b0001);
        en = '{12, 0, 0, 0};
        run(22);
        // simultaneous presses of widths 1, 3, 4 and 6
        en = '{1, 3, 4, 6};
        run(16);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (sb.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
